// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode/state types and opcode legality helper for calc_sched
package calc_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_SUM  = 3'd1,
    OP_MULT = 3'd2,
    OP_SUB  = 3'd3,
    OP_SQRT = 3'd4,
    OP_DIV  = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op >= OP_SUM) && (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/calc_sched_if.sv
// rtl/calc_sched_if.sv - requester, response and datapath signal bundle for calc_sched
interface calc_sched_if
  import calc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [OPW*NREQ-1:0] req_opcode;
  logic [DW*NREQ-1:0]  req_in1;
  logic [DW*NREQ-1:0]  req_in2;
  logic [NREQ-1:0]     req_sel;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [2*DW-1:0]     rsp_result;
  logic                rsp_err;
  logic [OPW-1:0]      calc_opcode;
  logic [DW-1:0]       calc_op_in1;
  logic [DW-1:0]       calc_op_in2;
  logic                calc_op_in_sel;
  logic [2*DW-1:0]     calc_result;
  logic                calc_valid_res;
  logic [7:0]          err_count;

  modport slave (
    input  req_valid, req_opcode, req_in1, req_in2, req_sel, rsp_ready,
    input  calc_result, calc_valid_res,
    output req_ready, rsp_valid, rsp_result, rsp_err,
    output calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel, err_count
  );

  modport master (
    output req_valid, req_opcode, req_in1, req_in2, req_sel, rsp_ready,
    output calc_result, calc_valid_res,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
    input  calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel, err_count
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant; pointer moves past the winner only on advance
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Indices at or above the pointer win first, then the wrapped-around ones.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
        o_grant[i] = 1'b1;
        w_idx      = PW'(i);
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i] && (i < int'(r_ptr))) begin
        o_grant[i] = 1'b1;
        w_idx      = PW'(i);
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
    end
  end

endmodule

// File: rtl/calc_sched.sv
// rtl/calc_sched.sv - shares one external calculator datapath among NREQ requesters
module calc_sched
  import calc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREQ = 2
) (
  input  logic         calc_clock,
  input  logic         calc_rst,
  calc_sched_if.slave  bus
);
  state_e          r_state;
  logic [NREQ-1:0] r_owner;
  logic [OPW-1:0]  r_op;
  logic [DW-1:0]   r_in1;
  logic [DW-1:0]   r_in2;
  logic            r_sel;
  logic [2*DW-1:0] r_result;
  logic            r_err;
  logic [7:0]      r_err_cnt;

  logic [NREQ-1:0] w_grant;
  logic [OPW-1:0]  w_op;
  logic [DW-1:0]   w_in1;
  logic [DW-1:0]   w_in2;
  logic            w_sel;
  logic            w_take;
  logic            w_busy;

  assign w_take = (r_state == ST_IDLE) && calc_rst && (|bus.req_valid);
  assign w_busy = (r_state == ST_ISSUE) || (r_state == ST_CAPTURE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_clk     (calc_clock),
    .i_rst_n   (calc_rst),
    .i_req     (bus.req_valid),
    .i_advance (w_take),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_op  = '0;
    w_in1 = '0;
    w_in2 = '0;
    w_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_op  = bus.req_opcode[OPW*i +: OPW];
        w_in1 = bus.req_in1[DW*i +: DW];
        w_in2 = bus.req_in2[DW*i +: DW];
        w_sel = bus.req_sel[i];
      end
    end
  end

  assign bus.req_ready      = w_take ? w_grant : '0;
  assign bus.rsp_valid      = (r_state == ST_RESP) ? r_owner : '0;
  assign bus.rsp_result     = r_result;
  assign bus.rsp_err        = r_err;
  assign bus.calc_opcode    = w_busy ? r_op  : '0;
  assign bus.calc_op_in1    = w_busy ? r_in1 : '0;
  assign bus.calc_op_in2    = w_busy ? r_in2 : '0;
  assign bus.calc_op_in_sel = w_busy ? r_sel : 1'b0;
  assign bus.err_count      = r_err_cnt;

  // Illegal opcodes skip the datapath entirely and answer with an error one cycle later.
  always_ff @(posedge calc_clock or negedge calc_rst) begin
    if (!calc_rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_op      <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_sel     <= 1'b0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_owner <= w_grant;
            r_op    <= w_op;
            r_in1   <= w_in1;
            r_in2   <= w_in2;
            r_sel   <= w_sel;
            if (op_legal(w_op)) begin
              r_state <= ST_ISSUE;
            end else begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= ST_RESP;
            end
          end
        end
        ST_ISSUE: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_result <= bus.calc_valid_res ? bus.calc_result : '0;
          r_err    <= ~bus.calc_valid_res;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (|(r_owner & bus.rsp_ready)) begin
            if (r_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// tb/tb_calc_sched.sv - self-checking bench for calc_sched with a transaction-level model
module tb_calc_sched;
  import calc_pkg::*;

  localparam int DW   = 32;
  localparam int NREQ = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  calc_sched_if #(.DW(DW), .NREQ(NREQ)) bus ();

  calc_sched #(.DW(DW), .NREQ(NREQ)) dut (
    .calc_clock (clk),
    .calc_rst   (rst_n),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Returns {overflow, raw result}; raw result is deliberately non-zero on overflow.
  function automatic logic [64:0] calc_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0] r;
    logic        ovf;
    logic [63:0] x;
    logic [63:0] q;
    logic [63:0] t;
    r = '0; ovf = 1'b0; x = '0; q = '0; t = '0;
    case (op)
      3'd1: begin r = {32'd0, a} + {32'd0, b}; ovf = r[32]; end
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: begin r = {32'd0, a} - {32'd0, b}; ovf = (a < b); end
      3'd4: begin
        x = {32'd0, (s ? a : b)};
        for (int k = 15; k >= 0; k--) begin
          t = q | (64'd1 << k);
          if (t * t <= x) q = t;
        end
        r = q;
      end
      3'd5: begin
        if (b == 32'd0) begin r = '1; ovf = 1'b1; end
        else r = {32'd0, a / b};
      end
      default: ;
    endcase
    return {ovf, r};
  endfunction

  // Registered external datapath.
  logic [64:0] stub_f;
  assign stub_f = calc_fn(bus.calc_opcode, bus.calc_op_in1, bus.calc_op_in2, bus.calc_op_in_sel);
  always @(posedge clk) begin
    bus.calc_result    <= stub_f[63:0];
    bus.calc_valid_res <= ~stub_f[64];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one transaction in flight, timed by cycles since acceptance.
  int          m_ptr = 0;
  int          m_owner = 0;
  int          m_age = 0;
  int          m_lat = 0;
  int          m_cnt = 0;
  bit          m_busy = 1'b0;
  bit          m_legal = 1'b0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_s = 1'b0;
  logic [63:0] m_res = '0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_vld;
    logic [2:0]      e_op;
    logic [31:0]     e_a;
    logic [31:0]     e_b;
    logic            e_s;
    logic [64:0]     f;
    int              g;
    e_rdy = '0; e_vld = '0; e_op = '0; e_a = '0; e_b = '0; e_s = 1'b0; f = '0; g = -1;
    if (!rst_n) begin
      m_busy = 1'b0; m_ptr = 0; m_cnt = 0;
      chk("rst_rsp_result", bus.rsp_result, 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    end else if (!m_busy) begin
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      if (g >= 0) e_rdy[g] = 1'b1;
    end else begin
      m_age++;
      if (m_legal && (m_age == 1 || m_age == 2)) begin
        e_op = m_op; e_a = m_a; e_b = m_b; e_s = m_s;
      end
      if (m_age >= m_lat) begin
        e_vld[m_owner] = 1'b1;
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
      end
    end
    chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_vld));
    chk("calc_opcode", 64'(bus.calc_opcode), 64'(e_op));
    chk("calc_op_in1", 64'(bus.calc_op_in1), 64'(e_a));
    chk("calc_op_in2", 64'(bus.calc_op_in2), 64'(e_b));
    chk("calc_op_in_sel", 64'(bus.calc_op_in_sel), 64'(e_s));
    chk("err_count", 64'(bus.err_count), 64'(m_cnt));
    if (rst_n) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_owner = g;
        m_op    = bus.req_opcode[3*g +: 3];
        m_a     = bus.req_in1[32*g +: 32];
        m_b     = bus.req_in2[32*g +: 32];
        m_s     = bus.req_sel[g];
        m_legal = (m_op >= 3'd1) && (m_op <= 3'd5);
        m_lat   = m_legal ? 3 : 1;
        f       = calc_fn(m_op, m_a, m_b, m_s);
        m_err   = m_legal ? f[64] : 1'b1;
        m_res   = m_err ? 64'd0 : f[63:0];
        m_ptr   = (g + 1) % NREQ;
        if (!m_legal) begin m_a = '0; m_b = '0; m_s = 1'b0; end
      end else if (m_busy && m_age >= m_lat && bus.rsp_ready[m_owner]) begin
        m_busy = 1'b0;
        if (m_err && m_cnt < 255) m_cnt++;
      end
    end
  end

  task automatic issue(input int idx, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic s, output int t_acc);
    @(posedge clk); #1;
    bus.req_valid[idx]          = 1'b1;
    bus.req_opcode[3*idx +: 3]  = op;
    bus.req_in1[32*idx +: 32]   = a;
    bus.req_in2[32*idx +: 32]   = b;
    bus.req_sel[idx]            = s;
    t_acc = -1;
    for (int k = 0; k < 12 && t_acc < 0; k++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) t_acc = cyc;
    end
    if (t_acc < 0) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output int t_rsp);
    t_rsp = -1;
    for (int k = 0; k < 12 && t_rsp < 0; k++) begin
      @(negedge clk);
      if (|bus.rsp_valid) t_rsp = cyc;
    end
    if (t_rsp < 0) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input int idx, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int exp_lat, input logic [63:0] exp_res, input logic exp_err);
    int ta;
    int tr;
    logic [NREQ-1:0] vmask;
    vmask = '0;
    vmask[idx] = 1'b1;
    issue(idx, op, a, b, s, ta);
    wait_rsp(tr);
    chk({name, "_latency"}, 64'(tr - ta), 64'(exp_lat));
    chk({name, "_valid"}, 64'(bus.rsp_valid), 64'(vmask));
    chk({name, "_result"}, bus.rsp_result, exp_res);
    chk({name, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
  endtask

  initial begin
    int ta;
    int tr;
    int ng;
    int t_rel;
    int nrsp;
    int gi[4];
    int gt[4];
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_in1    = '0;
    bus.req_in2    = '0;
    bus.req_sel    = '0;
    bus.rsp_ready  = '1;
    foreach (gi[i]) begin gi[i] = -1; gt[i] = -1; end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_err_count", 64'(bus.err_count), 64'd0);
    rst_n = 1'b1;

    run_op("sum_basic",  0, OP_SUM,  32'd5,         32'd7,         1'b0, 3, 64'd12, 1'b0);
    run_op("sum_ovf",    1, OP_SUM,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 64'd0,  1'b1);
    @(negedge clk);
    chk("err_count_after_ovf", 64'(bus.err_count), 64'd1);
    run_op("sub_basic",  0, OP_SUB,  32'd20,   32'd7,    1'b0, 3, 64'd13, 1'b0);
    run_op("sub_under",  1, OP_SUB,  32'd3,    32'd5,    1'b0, 3, 64'd0,  1'b1);
    run_op("sqrt_in1",   0, OP_SQRT, 32'd144,  32'd1000, 1'b1, 3, 64'd12, 1'b0);
    run_op("sqrt_in2",   1, OP_SQRT, 32'd1000, 32'd81,   1'b0, 3, 64'd9,  1'b0);
    run_op("div_basic",  0, OP_DIV,  32'd100,  32'd7,    1'b0, 3, 64'd14, 1'b0);
    run_op("div_zero",   1, OP_DIV,  32'd100,  32'd0,    1'b0, 3, 64'd0,  1'b1);
    run_op("illegal7",   1, 3'd7,    32'd1,    32'd2,    1'b0, 1, 64'd0,  1'b1);
    run_op("illegal0",   0, 3'd0,    32'd1,    32'd2,    1'b0, 1, 64'd0,  1'b1);
    run_op("illegal6",   1, 3'd6,    32'd1,    32'd2,    1'b1, 1, 64'd0,  1'b1);
    @(negedge clk);
    chk("err_count_after_six", 64'(bus.err_count), 64'd6);

    @(posedge clk); #1;
    bus.rsp_ready = '0;
    issue(0, OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0, ta);
    wait_rsp(tr);
    chk("mult_latency", 64'(tr - ta), 64'd3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("mult_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("mult_hold_result", bus.rsp_result, 64'h1_0000_0000);
    end
    @(posedge clk); #1;
    bus.rsp_ready = '1;
    @(negedge clk);
    chk("mult_last_valid", 64'(bus.rsp_valid), 64'd1);
    @(negedge clk);
    chk("mult_released", 64'(bus.rsp_valid), 64'd0);

    issue(0, OP_SUM, 32'd9, 32'd9, 1'b0, ta);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_calc_opcode", 64'(bus.calc_opcode), 64'd0);
    chk("midrst_calc_in1", 64'(bus.calc_op_in1), 64'd0);
    chk("midrst_rsp_result", bus.rsp_result, 64'd0);
    chk("midrst_err_count", 64'(bus.err_count), 64'd0);
    bus.req_opcode = {3'd2, 3'd1};
    bus.req_in1    = {32'd3, 32'd1};
    bus.req_in2    = {32'd4, 32'd2};
    bus.req_sel    = '0;
    bus.req_valid  = '1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    t_rel = cyc;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        gi[ng] = bus.req_ready[1] ? 1 : 0;
        gt[ng] = cyc;
        ng++;
      end
    end
    chk("rr_grant_count", 64'(ng), 64'd4);
    chk("rr_first_grant_time", 64'(gt[0] - t_rel), 64'd0);
    chk("rr_grant0", 64'(gi[0]), 64'd0);
    chk("rr_grant1", 64'(gi[1]), 64'd1);
    chk("rr_grant2", 64'(gi[2]), 64'd0);
    chk("rr_grant3", 64'(gi[3]), 64'd1);
    for (int i = 1; i < 4; i++) chk("rr_spacing", 64'(gt[i] - gt[i-1]), 64'd4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (6) @(negedge clk);

    @(posedge clk); #1;
    bus.req_opcode = '0;
    bus.req_valid  = 2'b01;
    nrsp = 0;
    for (int k = 0; k < 700 && nrsp < 260; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[0]) nrsp++;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    chk("sat_responses", 64'(nrsp), 64'd260);
    chk("sat_err_count", 64'(bus.err_count), 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sched.md
CALC_SCHED -- requirements
Module: calc_sched

Interface
REQ-001 Parameter DW, default 32, operand width; results are 2*DW wide.
REQ-002 Parameter NREQ, default 2, number of requesters sharing one calculator datapath (range 2..8).
REQ-003 calc_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 calc_rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester acceptance; at most one bit high per cycle.
REQ-007 req_opcode  input  3*NREQ  per-requester opcode, slice i = bits [3i+2:3i].
REQ-008 req_in1, req_in2  input  DW*NREQ each  per-requester operands, slice i = bits [DW*i+DW-1:DW*i].
REQ-009 req_sel  input  NREQ  per-requester square-root operand select (1 = in1, 0 = in2).
REQ-010 rsp_valid  output  NREQ  one-hot response valid to the owning requester.
REQ-011 rsp_ready  input  NREQ  per-requester response acceptance.
REQ-012 rsp_result  output  2*DW  shared response data; meaningful only while rsp_valid is non-zero.
REQ-013 rsp_err  output  1  response error flag, qualified by rsp_valid.
REQ-014 calc_opcode  output  3  opcode to datapath; calc_op_in1, calc_op_in2  output  DW; calc_op_in_sel  output  1.
REQ-015 calc_result  input  2*DW  registered datapath result; calc_valid_res  input  1  datapath no-overflow flag.
REQ-016 err_count  output  8  saturating count of error responses.

Function
REQ-017 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-018 IDLE: if any req_valid is high, grant one requester round-robin, assert its req_ready combinationally in that cycle, latch opcode/operands/sel into internal registers.
REQ-019 Round-robin: priority starts at the index after the last granted requester, wrapping NREQ-1 to 0; the pointer updates only on a grant.
REQ-020 Legal opcodes: 1..5 (SUM, MULT, SUB, SQRT, DIV); on 0, 6 or 7, IDLE goes straight to RESP with rsp_err=1 and rsp_result=0, and the datapath is never driven with that opcode.
REQ-021 Legal opcode: IDLE->ISSUE->CAPTURE->RESP, one cycle each in ISSUE and CAPTURE.
REQ-022 calc_* outputs drive the latched registers in ISSUE and CAPTURE, held stable across both cycles; in IDLE and RESP, calc_opcode=0 and operands=0.
REQ-023 CAPTURE: register calc_result into rsp_result and ~calc_valid_res into rsp_err; when calc_valid_res=0, store rsp_result=0.
REQ-024 RESP: rsp_valid bit of the owner is high, and rsp_result/rsp_err are held, until the owner's rsp_ready is high; then go to IDLE.
REQ-025 Latency: accept at cycle T means rsp_valid rises at T+3 for legal ops and T+1 for illegal ops.
REQ-026 req_ready is 0 in ISSUE, CAPTURE and RESP; there is no same-cycle RESP->accept bypass, so the minimum issue interval is 4 cycles.
REQ-027 rsp_ready bits of non-owners are ignored; req_valid deasserted without a grant is legal and has no effect.
REQ-028 err_count increments by 1 on each RESP exit with rsp_err=1 and saturates at 255.

Reset
REQ-029 Reset asserted (low) at any time, including mid-operation: state=IDLE, RR pointer=0 (requester 0 highest priority), req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, calc_* outputs=0, err_count=0; in-flight operations are discarded.
REQ-030 Reset deassertion is synchronised to calc_clock by the integrating top level; the block takes its first grant on the first edge after release.

Structure
REQ-031 A shared package calc_pkg holds the opcode enum (SUM=1, MULT=2, SUB=3, SQRT=4, DIV=5), the opcode width constant (3), and the FSM state enum.
REQ-032 Round-robin selection lives in one sub-module, rr_arbiter (parameter NREQ; inputs request vector and advance strobe; output one-hot grant), instantiated once.
REQ-033 The calculator instance sits outside this block, connected through the calc_* ports.

Verification
REQ-034 NREQ=2; req0 SUM in1=5 in2=7, rsp_ready=1 -> req_ready[0] at T, rsp_valid=01 at T+3, rsp_result=12, rsp_err=0.
REQ-035 req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1; each accept is spaced 4 cycles apart.
REQ-036 SUM in1=in2=32'hFFFF_FFFF -> rsp_err=1, rsp_result=0, err_count=1.
REQ-037 opcode=7 on req1 -> rsp_valid=10 at T+1, rsp_err=1, calc_opcode stays 0 throughout.
REQ-038 MULT in1=32'h1_0000 in2=32'h1_0000, rsp_ready held low 5 cycles -> rsp_valid and rsp_result=64'h1_0000_0000 held stable until rsp_ready, then IDLE.
REQ-039 Assert reset during CAPTURE -> all outputs 0 immediately, no response is issued, and the next grant after release goes to req0.
